// File: rtl/hs_pkg.sv
// Shared types and defaults for the dav_/rfd byte receiver.
package hs_pkg;

    localparam int unsigned DefaultW     = 8;
    localparam int unsigned DefaultDepth = 4;

    typedef enum logic [1:0] {
        StWaitDav = 2'd0,
        StWaitRel = 2'd1,
        StStall   = 2'd2
    } hs_state_e;

    // Unsigned 16-bit add that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/hs_if.sv
// Producer handshake plus downstream FIFO/statistics bus of the receiver.
interface hs_if
    import hs_pkg::*;
#(
    parameter int unsigned W     = DefaultW,
    parameter int unsigned DEPTH = DefaultDepth
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic          dav_;
    logic [W-1:0]  y;
    logic          rfd;
    logic          rd_en;
    logic [W-1:0]  dout;
    logic          empty;
    logic          full;
    logic [LW-1:0] level;
    logic [7:0]    count;
    logic [15:0]   sum;

    modport master (
        output dav_, y, rd_en,
        input  rfd, dout, empty, full, level, count, sum
    );

    modport slave (
        input  dav_, y, rd_en,
        output rfd, dout, empty, full, level, count, sum
    );

endinterface

// File: rtl/hs_fifo.sv
// Power-of-two FIFO with combinational head output; full/empty come from the level counter.
module hs_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [LW-1:0] level_q;
    logic          pop_eff;

    // A pop against an empty FIFO is simply dropped.
    assign pop_eff = pop && !empty;
    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign level   = level_q;
    assign rdata   = empty ? '0 : mem_q[rptr_q];

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop_eff) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({push, pop_eff})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    no_overflow: assert property (@(posedge clock) disable iff (reset) !(push && full));

endmodule

// File: rtl/hs_receiver.sv
// Consumer end of the dav_/rfd handshake: captures bytes into a FIFO and keeps count/sum.
module hs_receiver
    import hs_pkg::*;
#(
    parameter int unsigned W     = DefaultW,
    parameter int unsigned DEPTH = DefaultDepth
) (
    input logic  clock,
    input logic  reset,
    hs_if.slave  bus
);
    hs_state_e   state_q, state_d;
    logic        rfd_q, rfd_d;
    logic [7:0]  count_q;
    logic [15:0] sum_q;
    logic        push;
    logic        pop_eff;
    logic        fifo_empty;
    logic        fifo_full;

    assign pop_eff = bus.rd_en && !fifo_empty;

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            StWaitDav: begin
                if (!bus.dav_) begin
                    push    = 1'b1;
                    state_d = StWaitRel;
                end
            end
            StWaitRel: begin
                // Fullness is judged after this edge's pop has been applied.
                if (bus.dav_) begin
                    state_d = (fifo_full && !pop_eff) ? StStall : StWaitDav;
                end
            end
            StStall: begin
                if (!fifo_full) begin
                    state_d = StWaitDav;
                end
            end
            default: state_d = StWaitDav;
        endcase
        rfd_d = (state_d == StWaitDav);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StWaitDav;
            rfd_q   <= 1'b1;
            count_q <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            rfd_q   <= rfd_d;
            if (push) begin
                count_q <= count_q + 8'd1;
                sum_q   <= sat_add16(sum_q, 16'(bus.y));
            end
        end
    end

    hs_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .wdata (bus.y),
        .pop   (bus.rd_en),
        .rdata (bus.dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (bus.level)
    );

    assign bus.rfd   = rfd_q;
    assign bus.empty = fifo_empty;
    assign bus.full  = fifo_full;
    assign bus.count = count_q;
    assign bus.sum   = sum_q;

endmodule

// File: tb/tb_hs_receiver.sv
// Randomized and directed bench for hs_receiver against a queue-based reference model.
module tb_hs_receiver;
    import hs_pkg::*;

    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 4;
    localparam int PH_IDLE  = 0;
    localparam int PH_REL   = 1;
    localparam int PH_STALL = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    hs_if #(.W(W), .DEPTH(DEPTH)) bus ();

    hs_receiver #(
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    logic [7:0] mq[$];
    int m_phase = PH_IDLE;
    int m_count = 0;
    int m_sum   = 0;
    bit m_pop;
    bit m_push;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: phases of the handshake, a byte queue, and plain-integer statistics.
    always @(posedge clock) begin
        if (reset) begin
            mq.delete();
            m_phase = PH_IDLE;
            m_count = 0;
            m_sum   = 0;
        end else begin
            m_pop  = bus.rd_en && (mq.size() > 0);
            m_push = (m_phase == PH_IDLE) && !bus.dav_;
            case (m_phase)
                PH_IDLE:  if (!bus.dav_) m_phase = PH_REL;
                PH_REL:   if (bus.dav_)
                              m_phase = ((mq.size() - (m_pop ? 1 : 0)) == DEPTH) ? PH_STALL : PH_IDLE;
                default:  if (mq.size() < DEPTH) m_phase = PH_IDLE;
            endcase
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                mq.push_back(bus.y);
                m_count = (m_count + 1) % 256;
                m_sum   = (m_sum + int'(bus.y) > 65535) ? 65535 : m_sum + int'(bus.y);
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("rfd", 32'(bus.rfd), 32'(m_phase == PH_IDLE));
            chk("level", 32'(bus.level), mq.size());
            chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
            chk("full", 32'(bus.full), 32'(mq.size() == DEPTH));
            chk("count", 32'(bus.count), m_count);
            chk("sum", 32'(bus.sum), m_sum);
            if (mq.size() > 0) chk("dout", 32'(bus.dout), 32'(mq[0]));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.y    = b;
        bus.dav_ = 1'b0;
        tick();
        bus.dav_ = 1'b1;
        tick();
    endtask

    initial begin
        int pop_pct;
        bus.dav_  = 1'b1;
        bus.y     = '0;
        bus.rd_en = 1'b0;
        reset     = 1'b1;
        tick();
        chk_en = 1'b1;
        @(negedge clock);
        chk("rst_rfd", 32'(bus.rfd), 1);
        chk("rst_level", 32'(bus.level), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_dout", 32'(bus.dout), 0);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_sum", 32'(bus.sum), 0);
        reset = 1'b0;

        // Single byte.
        bus.y    = 8'h2A;
        bus.dav_ = 1'b0;
        tick();
        bus.dav_ = 1'b1;
        @(negedge clock);
        chk("one_rfd", 32'(bus.rfd), 0);
        chk("one_dout", 32'(bus.dout), 32'h2A);
        chk("one_level", 32'(bus.level), 1);
        chk("one_count", 32'(bus.count), 1);
        chk("one_sum", 32'(bus.sum), 42);
        tick();
        @(negedge clock);
        chk("one_release_rfd", 32'(bus.rfd), 1);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;

        // Fill to full, stall, then release one slot.
        for (int b = 1; b <= 4; b++) send_byte(8'(b));
        @(negedge clock);
        chk("fill_full", 32'(bus.full), 1);
        chk("fill_rfd", 32'(bus.rfd), 0);
        chk("fill_level", 32'(bus.level), 4);
        tick();
        tick();
        @(negedge clock);
        chk("stall_rfd", 32'(bus.rfd), 0);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        @(negedge clock);
        chk("pop_dout", 32'(bus.dout), 2);
        chk("pop_level", 32'(bus.level), 3);
        tick();
        @(negedge clock);
        chk("unstall_rfd", 32'(bus.rfd), 1);
        bus.rd_en = 1'b1;
        repeat (3) tick();
        bus.rd_en = 1'b0;

        // Simultaneous push and pop at level 2.
        send_byte(8'h11);
        send_byte(8'h22);
        bus.y     = 8'h33;
        bus.dav_  = 1'b0;
        bus.rd_en = 1'b1;
        tick();
        bus.dav_  = 1'b1;
        bus.rd_en = 1'b0;
        @(negedge clock);
        chk("pp_level", 32'(bus.level), 2);
        chk("pp_dout", 32'(bus.dout), 32'h22);
        tick();
        bus.rd_en = 1'b1;
        tick();
        @(negedge clock);
        chk("pp_order", 32'(bus.dout), 32'h33);
        tick();
        bus.rd_en = 1'b0;

        // Pop on empty.
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        @(negedge clock);
        chk("pe_level", 32'(bus.level), 0);
        chk("pe_empty", 32'(bus.empty), 1);
        chk("pe_count", 32'(bus.count), 8);
        chk("pe_sum", 32'(bus.sum), 154);

        // Reset in the release phase with three entries, then capture with dav_ still low.
        send_byte(8'h05);
        send_byte(8'h06);
        bus.y    = 8'h07;
        bus.dav_ = 1'b0;
        tick();
        @(negedge clock);
        chk("mid_level", 32'(bus.level), 3);
        reset = 1'b1;
        tick();
        @(negedge clock);
        chk("mr_rfd", 32'(bus.rfd), 1);
        chk("mr_level", 32'(bus.level), 0);
        chk("mr_count", 32'(bus.count), 0);
        chk("mr_sum", 32'(bus.sum), 0);
        reset = 1'b0;
        bus.y = 8'h5A;
        tick();
        @(negedge clock);
        chk("fresh_count", 32'(bus.count), 1);
        chk("fresh_dout", 32'(bus.dout), 32'h5A);
        chk("fresh_rfd", 32'(bus.rfd), 0);
        bus.dav_ = 1'b1;
        tick();

        // Saturation: 300 x 8'hFF with continuous pops.
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        bus.rd_en = 1'b1;
        repeat (300) send_byte(8'hFF);
        bus.rd_en = 1'b0;
        tick();
        @(negedge clock);
        chk("sat_sum", 32'(bus.sum), 32'hFFFF);
        chk("sat_count", 32'(bus.count), 44);
        chk("sat_empty", 32'(bus.empty), 1);

        // Random traffic with varying pop pressure and occasional resets.
        for (int blk = 0; blk < 15; blk++) begin
            pop_pct = (blk % 3 == 0) ? 5 : ((blk % 3 == 1) ? 35 : 70);
            for (int i = 0; i < 200; i++) begin
                reset     = ($urandom_range(0, 199) == 0);
                bus.dav_  = ($urandom_range(0, 99) < 45) ? 1'b0 : 1'b1;
                bus.y     = 8'($urandom);
                bus.rd_en = ($urandom_range(0, 99) < pop_pct);
                tick();
            end
        end
        reset     = 1'b0;
        bus.dav_  = 1'b1;
        bus.rd_en = 1'b0;
        tick();
        @(negedge clock);
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hs_receiver.md
HS_RECEIVER -- requirements
Module: hs_receiver

Interface
REQ-001 Parameter W, default 8: data width of the byte stream.
REQ-002 Parameter DEPTH, default 4: FIFO entries, power of two, 2 or more.
REQ-003 Port clock, input, 1: single clock, all state changes on posedge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port dav_, input, 1: producer data-valid, active low.
REQ-006 Port y, input, W: producer data, stable while dav_=0.
REQ-007 Port rfd, output, 1: ready-for-data to producer, registered.
REQ-008 Port rd_en, input, 1: downstream pop request.
REQ-009 Port dout, output, W: FIFO head entry, valid while empty=0.
REQ-010 Port empty, output, 1: FIFO holds no entries.
REQ-011 Port full, output, 1: FIFO holds DEPTH entries.
REQ-012 Port level, output, clog2(DEPTH)+1: current FIFO occupancy.
REQ-013 Port count, output, 8: bytes accepted since reset, wraps 255->0.
REQ-014 Port sum, output, 16: unsigned sum of accepted bytes, saturates at 16'hFFFF.

Function
REQ-015 The block SHALL be the consumer end of the dav_/rfd handshake: idle rfd=1; capture on dav_=0; drive rfd=0; wait for dav_=1; then restore rfd=1.
REQ-016 The handshake FSM SHALL have exactly three states: WAIT_DAV (rfd=1), WAIT_REL (rfd=0), STALL (rfd=0).
REQ-017 WAIT_DAV with dav_=0 SHALL push y into the FIFO, set rfd=0 and go to WAIT_REL in the same edge.
REQ-018 WAIT_DAV with dav_=1 SHALL hold.
REQ-019 WAIT_REL with dav_=1 SHALL go to STALL if full=1 after that edge's push/pop, else to WAIT_DAV with rfd=1.
REQ-020 WAIT_REL with dav_=0 SHALL hold with rfd=0.
REQ-021 STALL SHALL hold rfd=0 until full=0, then go to WAIT_DAV with rfd=1 on the next edge.
REQ-022 A push SHALL occur only in WAIT_DAV; overflow is therefore impossible and SHALL be asserted against in simulation.
REQ-023 rd_en=1 with empty=0 SHALL pop one entry, so dout advances to the next entry one cycle later.
REQ-024 rd_en=1 with empty=1 SHALL be ignored, with no state change.
REQ-025 Simultaneous push and pop SHALL leave level unchanged; on an empty FIFO, the pop is ignored and the push proceeds.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; full/empty SHALL be derived from level, not from pointer equality.
REQ-027 On each push, count SHALL increment modulo 256.
REQ-028 On each push, sum SHALL become min(sum + y, 16'hFFFF) and SHALL stay at 16'hFFFF once saturated.
REQ-029 Capture latency SHALL be one edge: the pushed byte appears on dout on that edge if the FIFO was empty.

Reset
REQ-030 reset=1 at a posedge SHALL set the FSM to WAIT_DAV, rfd=1, level=0, empty=1, full=0, dout=0, count=0, sum=0 and both pointers to 0.
REQ-031 Reset asserted mid-handshake SHALL discard FIFO contents.
REQ-032 After reset released with dav_=0 still low, the next posedge SHALL capture y as a fresh byte.
REQ-033 reset SHALL take priority over dav_ and rd_en on the same edge.

Structure
REQ-034 The FSM state encoding and the default DEPTH/W constants SHALL live in the shared package hs_pkg.
REQ-035 FIFO storage, pointers and level SHALL be one sub-module, hs_fifo.
REQ-036 The FSM, count and sum SHALL stay in hs_receiver.

Verification
REQ-037 The bench SHALL cover a single byte: y=8'h2A with dav_ low -> next edge rfd=0, dout=8'h2A, level=1, count=1, sum=42; dav_ high -> rfd=1.
REQ-038 The bench SHALL cover filling the FIFO: 4 bytes 1,2,3,4 with no pops -> full=1, FSM in STALL, rfd stays 0; one rd_en -> dout=2, level=3, rfd=1 next edge.
REQ-039 The bench SHALL cover saturation: 300 bytes of 8'hFF with continuous pops -> sum=16'hFFFF, count=44.
REQ-040 The bench SHALL cover simultaneous push and pop at level=2 -> level stays 2 and dout order is preserved.
REQ-041 The bench SHALL cover a pop on empty: rd_en=1 at level=0 -> no change, empty stays 1.
REQ-042 The bench SHALL cover reset in WAIT_REL with level=3 -> next edge rfd=1, level=0, count=0, sum=0.
